// File: rtl/spi_slave_if.sv
// SPI mode-0 responder running entirely on the system clock with oversampled pins.
// A byte-wide tx holding register and an rx data register with full and overrun flags face the local side.
module spi_slave_if #(
    parameter int         SYNC_STAGES = 2,
    parameter logic       IDLE_MISO   = 1'b1,
    parameter logic [7:0] DUMMY_BYTE  = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SCLK,
    input  logic       SSn,
    input  logic       MOSI,
    output logic       MISO,
    output logic       MISO_OE,
    input  logic [7:0] txdin,
    input  logic       txload,
    output logic       txrdy,
    output logic [7:0] rxdout,
    output logic       rxvalid,
    output logic       rxfull,
    input  logic       rxack,
    output logic       rxovr,
    output logic       busy
);

    typedef enum logic {ST_IDLE, ST_ACTIVE} state_e;

    logic [SYNC_STAGES-1:0] sclk_sync_q, ssn_sync_q, mosi_sync_q;
    logic                   sclk_dly_q, ssn_dly_q;
    logic                   sclk_rise_q, sclk_fall_q, ssn_fall_q, ssn_rise_q;
    logic                   mosi_q;

    state_e     state_q, state_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic [6:0] rx_shift_q, rx_shift_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] hold_q, hold_d;
    logic       txrdy_q, txrdy_d;
    logic [7:0] rxdout_q, rxdout_d;
    logic       rxvalid_q, rxvalid_d;
    logic       rxfull_q, rxfull_d;
    logic       rxovr_q, rxovr_d;
    logic       miso_q, miso_d;
    logic       oe_q, oe_d;
    logic       busy_q, busy_d;

    logic       sclk_s, ssn_s, mosi_s;
    logic       take_hold;
    logic [7:0] next_tx;

    assign sclk_s  = sclk_sync_q[SYNC_STAGES-1];
    assign ssn_s   = ssn_sync_q[SYNC_STAGES-1];
    assign mosi_s  = mosi_sync_q[SYNC_STAGES-1];
    // An empty holding register means the master clocks out the dummy byte
    assign next_tx = txrdy_q ? DUMMY_BYTE : hold_q;

    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        hold_d     = hold_q;
        txrdy_d    = txrdy_q;
        rxdout_d   = rxdout_q;
        rxvalid_d  = 1'b0;
        rxfull_d   = rxfull_q;
        rxovr_d    = rxovr_q;
        miso_d     = miso_q;
        oe_d       = oe_q;
        busy_d     = busy_q;
        take_hold  = 1'b0;

        if (rxack) begin
            rxfull_d = 1'b0;
            rxovr_d  = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (ssn_fall_q) begin
                    state_d    = ST_ACTIVE;
                    bitcnt_d   = 3'd0;
                    take_hold  = 1'b1;
                    tx_shift_d = next_tx;
                    miso_d     = next_tx[7];
                    oe_d       = 1'b1;
                    busy_d     = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (ssn_rise_q) begin
                    state_d  = ST_IDLE;
                    bitcnt_d = 3'd0;
                    miso_d   = IDLE_MISO;
                    oe_d     = 1'b0;
                    busy_d   = 1'b0;
                end else if (sclk_rise_q) begin
                    rx_shift_d = {rx_shift_q[5:0], mosi_q};
                    bitcnt_d   = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        rxdout_d  = {rx_shift_q, mosi_q};
                        rxvalid_d = 1'b1;
                        rxfull_d  = 1'b1;
                        if (rxfull_q && !rxack) begin
                            rxovr_d = 1'b1;
                        end
                    end
                end else if (sclk_fall_q) begin
                    if (bitcnt_q != 3'd0) begin
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                        miso_d     = tx_shift_q[6];
                    end else begin
                        take_hold  = 1'b1;
                        tx_shift_d = next_tx;
                        miso_d     = next_tx[7];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A transfer empties the holding register before a same-cycle load refills it
        if (take_hold && !txrdy_q) begin
            txrdy_d = 1'b1;
        end
        if (txload && txrdy_d) begin
            hold_d  = txdin;
            txrdy_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q <= '0;
            ssn_sync_q  <= '1;
            mosi_sync_q <= '1;
            sclk_dly_q  <= 1'b0;
            ssn_dly_q   <= 1'b1;
            sclk_rise_q <= 1'b0;
            sclk_fall_q <= 1'b0;
            ssn_fall_q  <= 1'b0;
            ssn_rise_q  <= 1'b0;
            state_q     <= ST_IDLE;
            bitcnt_q    <= 3'd0;
            txrdy_q     <= 1'b1;
            rxdout_q    <= 8'h00;
            rxvalid_q   <= 1'b0;
            rxfull_q    <= 1'b0;
            rxovr_q     <= 1'b0;
            miso_q      <= IDLE_MISO;
            oe_q        <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
            ssn_sync_q  <= {ssn_sync_q[SYNC_STAGES-2:0], SSn};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
            sclk_dly_q  <= sclk_s;
            ssn_dly_q   <= ssn_s;
            // Registered edge strobes; MOSI is delayed alongside to stay aligned with them
            sclk_rise_q <= sclk_s & ~sclk_dly_q;
            sclk_fall_q <= ~sclk_s & sclk_dly_q;
            ssn_fall_q  <= ~ssn_s & ssn_dly_q;
            ssn_rise_q  <= ssn_s & ~ssn_dly_q;
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            txrdy_q     <= txrdy_d;
            rxdout_q    <= rxdout_d;
            rxvalid_q   <= rxvalid_d;
            rxfull_q    <= rxfull_d;
            rxovr_q     <= rxovr_d;
            miso_q      <= miso_d;
            oe_q        <= oe_d;
            busy_q      <= busy_d;
        end
        mosi_q     <= mosi_s;
        rx_shift_q <= rx_shift_d;
        tx_shift_q <= tx_shift_d;
        hold_q     <= hold_d;
    end

    assign MISO    = miso_q;
    assign MISO_OE = oe_q;
    assign txrdy   = txrdy_q;
    assign rxdout  = rxdout_q;
    assign rxvalid = rxvalid_q;
    assign rxfull  = rxfull_q;
    assign rxovr   = rxovr_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: a bench-side SPI master at clk/8 plus a byte-level
// behavioural model whose effects land SYNC_STAGES+2 clocks after each pin edge.
module tb_spi_slave_if;

    localparam int         SYNC  = 2;
    localparam int         L     = SYNC + 2;
    localparam int         HALF  = 4;
    localparam logic       IDLE  = 1'b1;
    localparam logic [7:0] DUMMY = 8'hFF;

    logic       clk = 1'b0, rst = 1'b1;
    logic       sclk = 1'b0, ssn = 1'b1, mosi = 1'b1;
    logic       txload = 1'b0, rxack = 1'b0;
    logic [7:0] txdin = 8'h00;
    logic       miso, miso_oe, txrdy, rxvalid, rxfull, rxovr, busy;
    logic [7:0] rxdout;

    spi_slave_if #(.SYNC_STAGES(SYNC), .IDLE_MISO(IDLE), .DUMMY_BYTE(DUMMY)) dut (
        .clk(clk), .rst(rst), .SCLK(sclk), .SSn(ssn), .MOSI(mosi),
        .MISO(miso), .MISO_OE(miso_oe), .txdin(txdin), .txload(txload),
        .txrdy(txrdy), .rxdout(rxdout), .rxvalid(rxvalid), .rxfull(rxfull),
        .rxack(rxack), .rxovr(rxovr), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, nvalid = 0, n0 = 0;
    bit chk_en = 1'b0;

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b t=%0t", nm, act, exp, $time);
        end
    endtask
    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask
    task automatic chki(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: current tx byte plus bit index, rise count, rx byte assembly
    logic [7:0] m_hold, m_tx, m_rx, m_rxdout;
    logic       m_txrdy, m_miso, m_oe, m_busy, m_rxvalid, m_rxfull, m_rxovr, m_active;
    int         m_nf, m_rbits;

    task automatic m_reset();
        m_txrdy = 1'b1; m_miso = IDLE; m_oe = 1'b0; m_busy = 1'b0;
        m_rxdout = 8'h00; m_rxvalid = 1'b0; m_rxfull = 1'b0; m_rxovr = 1'b0;
        m_active = 1'b0; m_rbits = 0; m_nf = 0; m_rx = 8'h00;
    endtask
    task automatic m_next_byte();
        if (!m_txrdy) begin m_tx = m_hold; m_txrdy = 1'b1; end
        else m_tx = DUMMY;
        m_nf = 0;
        m_miso = m_tx[7];
    endtask
    task automatic m_ss_fall();
        m_active = 1'b1; m_rbits = 0; m_oe = 1'b1; m_busy = 1'b1;
        m_next_byte();
    endtask
    task automatic m_ss_rise();
        m_active = 1'b0; m_rbits = 0; m_miso = IDLE; m_oe = 1'b0; m_busy = 1'b0;
    endtask
    task automatic m_rise(input logic b, input bit ack);
        if (m_active) begin
            m_rx = {m_rx[6:0], b};
            m_rbits = (m_rbits + 1) % 8;
            if (m_rbits == 0) begin
                m_rxdout = m_rx; m_rxvalid = 1'b1;
                if (ack) begin m_rxfull = 1'b1; m_rxovr = 1'b0; end
                else begin
                    if (m_rxfull) m_rxovr = 1'b1;
                    m_rxfull = 1'b1;
                end
            end
        end
    endtask
    task automatic m_fall();
        logic [7:0] t;
        if (m_active) begin
            if (m_rbits != 0) begin
                m_nf++;
                t = m_tx << m_nf;
                m_miso = t[7];
            end else m_next_byte();
        end
    endtask

    always @(negedge clk) if (rxvalid === 1'b1) nvalid++;

    always @(negedge clk) begin
        if (chk_en) begin
            chk1("miso", miso, m_miso);
            chk1("miso_oe", miso_oe, m_oe);
            chk1("txrdy", txrdy, m_txrdy);
            chk8("rxdout", rxdout, m_rxdout);
            chk1("rxvalid", rxvalid, m_rxvalid);
            chk1("rxfull", rxfull, m_rxfull);
            chk1("rxovr", rxovr, m_rxovr);
            chk1("busy", busy, m_busy);
            m_rxvalid = 1'b0;
        end
    end

    // All stimulus tasks start and end at 1 time unit after a rising clk edge
    task automatic wait_cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask
    task automatic load(input logic [7:0] d);
        txdin = d; txload = 1'b1; wait_cyc(1); txload = 1'b0;
        if (m_txrdy) begin m_hold = d; m_txrdy = 1'b0; end
    endtask
    task automatic ack();
        rxack = 1'b1; wait_cyc(1); rxack = 1'b0;
        m_rxfull = 1'b0; m_rxovr = 1'b0;
    endtask
    task automatic ss_fall(input logic first_bit);
        ssn = 1'b0; mosi = first_bit;
        wait_cyc(L); m_ss_fall(); wait_cyc(HALF - L);
    endtask
    task automatic ss_rise();
        ssn = 1'b1; wait_cyc(L); m_ss_rise(); wait_cyc(2);
    endtask
    task automatic rise(input bit ackit, output logic s);
        sclk = 1'b1; s = miso;
        if (ackit) begin wait_cyc(L - 1); rxack = 1'b1; wait_cyc(1); rxack = 1'b0; end
        else wait_cyc(L);
        m_rise(mosi, ackit);
        wait_cyc(HALF - L);
    endtask
    task automatic fall(input logic nxt);
        sclk = 1'b0; mosi = nxt;
        wait_cyc(L); m_fall(); wait_cyc(HALF - L);
    endtask
    function automatic logic bit_at(input logic [15:0] v, input int k);
        logic [15:0] t;
        t = v >> k;
        return t[0];
    endfunction
    task automatic frame(input int nb, input logic [15:0] mo, input bit ack_last,
                         output logic [15:0] mi);
        logic s;
        mi = 16'h0000;
        ss_fall(bit_at(mo, 8*nb - 1));
        for (int i = 0; i < 8*nb; i++) begin
            rise(ack_last && (i == 8*nb - 1), s);
            mi = {mi[14:0], s};
            fall((i < 8*nb - 1) ? bit_at(mo, 8*nb - 2 - i) : 1'b1);
        end
        ss_rise();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] got;
        logic        s;
        m_hold = 8'h00; m_tx = 8'h00;
        @(posedge clk); #1;
        m_reset(); chk_en = 1'b1;
        wait_cyc(3);
        chk1("rst_miso", miso, 1'b1);
        chk1("rst_oe", miso_oe, 1'b0);
        chk1("rst_txrdy", txrdy, 1'b1);
        chk8("rst_rxdout", rxdout, 8'h00);
        chk1("rst_busy", busy, 1'b0);
        rst = 1'b0;
        wait_cyc(3);

        // 1: loaded byte returned while 3C is received
        load(8'hA5);
        chk1("t1_txrdy_loaded", txrdy, 1'b0);
        n0 = nvalid;
        frame(1, 16'h003C, 1'b0, got);
        chk8("t1_master_rx", got[7:0], 8'hA5);
        chk8("t1_rxdout", rxdout, 8'h3C);
        chki("t1_rxvalid_pulses", nvalid - n0, 1);
        chk1("t1_rxfull", rxfull, 1'b1);
        chk1("t1_txrdy", txrdy, 1'b1);

        // 2: nothing loaded gives the dummy byte
        ack();
        frame(1, 16'h0081, 1'b0, got);
        chk8("t2_master_rx", got[7:0], 8'hFF);
        chk8("t2_rxdout", rxdout, 8'h81);
        chk1("t2_rxovr", rxovr, 1'b0);

        // 3: two-byte stream, second tx byte loaded mid-frame
        ack();
        load(8'h11);
        n0 = nvalid;
        fork
            frame(2, 16'hC35A, 1'b0, got);
            begin wait_cyc(12); load(8'h22); end
        join
        chk8("t3_master_rx0", got[15:8], 8'h11);
        chk8("t3_master_rx1", got[7:0], 8'h22);
        chk8("t3_rxdout", rxdout, 8'h5A);
        chki("t3_rxvalid_pulses", nvalid - n0, 2);
        chk1("t3_rxovr", rxovr, 1'b1);

        // 4: aborted frame after 5 SCLK edges, then a full frame
        ack();
        n0 = nvalid;
        ss_fall(1'b1);
        rise(1'b0, s); fall(1'b1);
        rise(1'b0, s); fall(1'b1);
        rise(1'b0, s);
        ss_rise();
        sclk = 1'b0; wait_cyc(HALF);
        chki("t4_no_rxvalid", nvalid - n0, 0);
        chk8("t4_rxdout_kept", rxdout, 8'h5A);
        chk1("t4_miso_idle", miso, 1'b1);
        chk1("t4_oe", miso_oe, 1'b0);
        chk1("t4_busy", busy, 1'b0);
        frame(1, 16'h000F, 1'b0, got);
        chk8("t4_rxdout", rxdout, 8'h0F);

        // 5: rxack coincident with byte completion
        chk1("t5_rxfull_before", rxfull, 1'b1);
        frame(1, 16'h0077, 1'b1, got);
        chk8("t5_rxdout", rxdout, 8'h77);
        chk1("t5_rxfull", rxfull, 1'b1);
        chk1("t5_rxovr", rxovr, 1'b0);

        // 6: second load ignored while full, then reset mid-frame
        load(8'h12);
        load(8'h34);
        chk1("t6_txrdy", txrdy, 1'b0);
        frame(1, 16'h0096, 1'b0, got);
        chk8("t6_master_rx", got[7:0], 8'h12);
        n0 = nvalid;
        ss_fall(1'b0);
        rise(1'b0, s); fall(1'b1);
        load(8'h5C);
        rise(1'b0, s);
        rst = 1'b1; ssn = 1'b1; sclk = 1'b0; mosi = 1'b1;
        wait_cyc(1);
        m_reset();
        wait_cyc(L + 2);
        chk1("t6_rst_miso", miso, 1'b1);
        chk1("t6_rst_oe", miso_oe, 1'b0);
        chk1("t6_rst_txrdy", txrdy, 1'b1);
        chk8("t6_rst_rxdout", rxdout, 8'h00);
        chk1("t6_rst_rxfull", rxfull, 1'b0);
        chk1("t6_rst_busy", busy, 1'b0);
        rst = 1'b0;
        wait_cyc(L + 4);
        chki("t6_no_rxvalid", nvalid - n0, 0);
        chk1("t6_post_busy", busy, 1'b0);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_slave_if.md
Name: spi_slave_if

Overview:
SPI mode-0 responder (slave). It is the far end of the SPI master used by the AHB SPI peripheral: it receives MOSI bytes and returns MISO bytes, and is clocked entirely by the system clock with SPI pins oversampled. It is used as an on-chip SPI target (for example, an accelerometer model or board-to-board link) and as a loopback partner for verifying the master. The local side is a byte-wide holding-register handshake for an AHB wrapper or test logic.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops on SCLK, SSn and MOSI (minimum 2).
IDLE_MISO, 1'b1, MISO level driven while deselected and after reset (SPI lines idle at 1).
DUMMY_BYTE, 8'hFF, byte shifted out when no tx byte has been loaded.

Ports:
clk  in  1  system clock; all logic on its rising edge.
rst  in  1  synchronous reset, active high.
SCLK  in  1  SPI clock from the master, asynchronous.
SSn  in  1  slave select from the master, active low, asynchronous.
MOSI  in  1  serial data from the master, asynchronous.
MISO  out  1  serial data to the master.
MISO_OE  out  1  high while selected; the top level uses it for a tristate.
txdin  in  8  byte to transmit on the next frame.
txload  in  1  one-cycle strobe; captures txdin when txrdy=1.
txrdy  out  1  tx holding register empty.
rxdout  out  8  last complete received byte.
rxvalid  out  1  one-cycle pulse when rxdout updates.
rxfull  out  1  unread byte present in rxdout.
rxack  in  1  clears rxfull and rxovr.
rxovr  out  1  sticky flag: a byte completed while rxfull=1.
busy  out  1  SSn (synchronised) low.

Behaviour:
- **Reset** (rst=1 at a clk edge): MISO=IDLE_MISO, MISO_OE=0, txrdy=1, rxdout=8'h00, rxvalid=0, rxfull=0, rxovr=0, busy=0, bit counter=0, synchronisers loaded with idle values (SCLK=0, SSn=1, MOSI=1). Reset mid-frame aborts the frame with no rxvalid.
- **Synchronisation**: SCLK, SSn and MOSI pass through SYNC_STAGES flops. Edges are detected by comparing the last stage with one extra delayed copy. The external SCLK must be at most clk/8, with at least 4 clk of setup from SSn fall to the first SCLK rise.
- **States**:
  - IDLE: SSn_s=1.
  - ACTIVE: SSn_s=0.
  - IDLE->ACTIVE on SSn_s fall: bitcnt=0. Load the tx shift register from the holding register if txrdy=0 (then txrdy goes to 1 next cycle), else load DUMMY_BYTE. MISO=shift[7], MISO_OE=1, busy=1.
  - ACTIVE->IDLE on SSn_s rise (any bitcnt): partial rx byte discarded, bitcnt=0, MISO=IDLE_MISO, MISO_OE=0. The holding register is untouched.
- **SCLK rise in ACTIVE**: rx_shift <= {rx_shift[6:0], MOSI_s}; bitcnt <= bitcnt+1 (3-bit, wraps 7->0).
  - When bitcnt was 7: rxdout <= {rx_shift[6:0], MOSI_s}, rxvalid=1 for exactly one clk, rxfull=1.
  - If rxfull was already 1 and rxack is not asserted that cycle, rxovr=1. rxdout is still overwritten with the new byte.
- **SCLK fall in ACTIVE**:
  - bitcnt≠0: tx shift left, MISO=new shift[7].
  - bitcnt=0 (byte boundary, continuous frame): reload from the holding register (txrdy->1) or DUMMY_BYTE, and MISO=new MSB. Multi-byte frames therefore stream back-to-back.
- **SCLK edges while IDLE** are ignored.
- **Tx handshake**:
  - txload with txrdy=1: holding <= txdin, txrdy=0 next cycle.
  - txload with txrdy=0: ignored, no state change.
  - txload in the same cycle the holding register is transferred: the transfer happens first, txdin is captured, and txrdy stays 0.
- **Rx handshake**:
  - rxack clears rxfull and rxovr the next cycle.
  - rxack coincident with a byte completion: the new byte is stored, rxfull stays 1, rxovr is not set.
- **Latency**: rxvalid rises SYNC_STAGES+2 clk after the 8th SCLK rising pin edge. MISO updates SYNC_STAGES+2 clk after an SCLK falling pin edge or the SSn falling pin edge.
- Bit order is MSB first in both directions.

Test Plan:
1. Reset, then load txdin=8'hA5 with txload. Master sends 8'h3C in one 8-bit frame at clk/8 -> master receives 8'hA5; rxdout=8'h3C; one rxvalid pulse; rxfull=1; txrdy=1 after SSn fall.
2. No txload, master sends 8'h81 -> master receives 8'hFF (DUMMY_BYTE); rxdout=8'h81.
3. 2-byte continuous frame with 8'h11 loaded and 8'h22 loaded while the first byte shifts; master sends 8'hC3 then 8'h5A -> master receives 8'h11 then 8'h22; two rxvalid pulses; rxdout=8'h5A; rxovr=1 (no rxack between bytes).
4. SSn raised after 5 SCLK edges of byte 8'hF0 -> no rxvalid, rxdout unchanged, MISO=1, MISO_OE=0, busy=0. The next full frame with 8'h0F gives rxdout=8'h0F.
5. rxack in the exact clk where byte 8'h77 completes, with rxfull=1 beforehand -> rxdout=8'h77, rxfull=1, rxovr=0.
6. txload twice (8'h12 then 8'h34) while txrdy=0 -> the holding register keeps 8'h12, and the master receives 8'h12. Assert rst mid-frame -> all outputs return to their reset values.
